// File: rtl/sd_hc_regs_pkg.sv
// sd_hc_regs_pkg: word addresses, access types and default constants for the SD host register file
package sd_hc_regs_pkg;
  typedef enum logic [2:0] {RW, RO, W1C, WO, RSVD} acc_t;
  localparam int ADDR_SDMA = 0, ADDR_BLK = 1, ADDR_ARG = 2, ADDR_CMD = 3, ADDR_RESP0 = 4, ADDR_RESP3 = 7;
  localparam int ADDR_BUFDATA = 8, ADDR_PSTATE = 9, ADDR_HOSTCTL = 10, ADDR_CLKCTL = 11, ADDR_INTSTAT = 12;
  localparam int ADDR_INTEN = 13, ADDR_INTSIG = 14, ADDR_ACMD12 = 15, ADDR_CAPS = 16, ADDR_FORCE = 20;
  localparam int ADDR_VERSION = 25;
  localparam logic [31:0] CAPS_DEFAULT = 32'h0000_0000;
  localparam logic [15:0] HC_VERSION_DEFAULT = 16'h0002;
  function automatic acc_t acc_type(input int a);
    case (a)
      0, 1, 2, 3, 8, 10, 11, 13, 14, 22, 23: acc_type = RW;
      4, 5, 6, 7, 9, 15, 16, 17, 18, 19, 25: acc_type = RO;
      12: acc_type = W1C;
      20: acc_type = WO;
      default: acc_type = RSVD;
    endcase
  endfunction
endpackage

// File: rtl/sd_int_status.sv
// sd_int_status: one half of the interrupt status (enable-gated set, W1C clear, set wins) and its irq contribution
module sd_int_status #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] set,
  input  logic [W-1:0] en,
  input  logic [W-1:0] w1c,
  input  logic [W-1:0] ie,
  output logic [W-1:0] status,
  output logic         pend
);
  always_ff @(posedge clk)
    status <= (reset || clr) ? '0 : (status & ~w1c) | (set & en);
  assign pend = |(status & ie);
endmodule

// File: rtl/sd_host_regfile_v2.sv
// sd_host_regfile_v2: SD host controller register file with req/ack CPU port, status merging and interrupt
module sd_host_regfile_v2
  import sd_hc_regs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 28,
  parameter int SRST_CYCLES = 4,
  parameter logic [31:0] CAPS_VALUE = CAPS_DEFAULT,
  parameter logic [15:0] HC_VERSION = HC_VERSION_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    rw,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ack,
  output logic                    err,
  input  logic                    hw_resp_we,
  input  logic [127:0]            hw_resp_data,
  input  logic [31:0]             hw_present_state,
  input  logic [15:0]             hw_nint_set,
  input  logic [15:0]             hw_eint_set,
  input  logic [15:0]             hw_acmd12_err,
  output logic [31:0]             cmd_argument,
  output logic [15:0]             transfer_mode,
  output logic [15:0]             command,
  output logic [15:0]             block_size,
  output logic [15:0]             block_count,
  output logic [31:0]             host_control,
  output logic [15:0]             clock_control,
  output logic [7:0]              timeout_control,
  output logic                    cmd_start,
  output logic                    srst_all,
  output logic                    srst_cmd,
  output logic                    srst_dat,
  output logic                    irq
);
  localparam int NW = 2**ADDR_WIDTH;
  localparam int CW = $clog2(SRST_CYCLES + 1);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;
  logic [31:0] regs [NW];
  logic [2:0] srst_q, srst_new;
  logic [CW-1:0] cnt_q;
  logic [15:0] nint, eint, force_v;
  logic nint_pend, eint_pend, accept, bad, wr, sra;
  logic [31:0] bmask, w1c, rd;
  int a;
  acc_t acc;
  always_comb begin
    accept = state_q == IDLE && req;
    state_d = accept ? ACK : IDLE;
    a = int'(addr);
    acc = acc_type(a);
    bad = a >= NUM_REGS || acc == RSVD;
    wr = accept && !rw && !bad;
    bmask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    w1c = (wr && a == ADDR_INTSTAT) ? data_in & bmask : '0;
    force_v = (wr && a == ADDR_FORCE) ? data_in[31:16] & bmask[31:16] : '0;
    srst_new = (wr && a == ADDR_CLKCTL) ? data_in[26:24] & {3{byte_en[3]}} : '0;
    sra = srst_new[0];
    rd = bad ? '0 :
         a == ADDR_PSTATE ? hw_present_state :
         a == ADDR_CLKCTL ? {5'b0, srst_q, regs[ADDR_CLKCTL][23:0]} :
         a == ADDR_INTSTAT ? {eint, nint[15] | (|eint), nint[14:0]} :
         a == ADDR_ACMD12 ? {16'b0, hw_acmd12_err} :
         a == ADDR_CAPS ? CAPS_VALUE :
         a == ADDR_VERSION ? {HC_VERSION, 15'b0, irq} :
         regs[addr];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_out <= '0;
      err <= 1'b0;
      cmd_start <= 1'b0;
      irq <= 1'b0;
      srst_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NW; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept && rw) data_out <= rd;
      err <= accept && bad;
      cmd_start <= wr && a == ADDR_CMD && byte_en[3];
      irq <= nint_pend | eint_pend | (regs[ADDR_INTSIG][15] & (|eint));
      if (|srst_new) begin
        srst_q <= srst_q | srst_new;
        cnt_q <= CW'(SRST_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) srst_q <= '0;
      end
      // response load beats the software reset clear, which beats CPU writes
      for (int i = 0; i < NW; i++)
        if (hw_resp_we && i >= ADDR_RESP0 && i <= ADDR_RESP3) regs[i] <= hw_resp_data[32*(i%4) +: 32];
        else if (sra && i != ADDR_CLKCTL) regs[i] <= '0;
        else if (wr && a == i && acc == RW)
          regs[i] <= (regs[i] & ~(i == ADDR_CLKCTL ? bmask & 32'h00FF_FFFF : bmask)) |
                     (data_in & (i == ADDR_CLKCTL ? bmask & 32'h00FF_FFFF : bmask));
    end
  end
  assign ack = state_q == ACK;
  sd_int_status #(.W(16)) u_nint (
    .clk(clk), .reset(reset), .clr(sra), .set(hw_nint_set), .en({1'b0, regs[ADDR_INTEN][14:0]}),
    .w1c(w1c[15:0]), .ie(regs[ADDR_INTSIG][15:0]), .status(nint), .pend(nint_pend)
  );
  sd_int_status #(.W(16)) u_eint (
    .clk(clk), .reset(reset), .clr(sra), .set(hw_eint_set | force_v), .en(regs[ADDR_INTEN][31:16]),
    .w1c(w1c[31:16]), .ie(regs[ADDR_INTSIG][31:16]), .status(eint), .pend(eint_pend)
  );
  assign cmd_argument = regs[ADDR_ARG];
  assign transfer_mode = regs[ADDR_CMD][15:0];
  assign command = regs[ADDR_CMD][31:16];
  assign block_size = regs[ADDR_BLK][15:0];
  assign block_count = regs[ADDR_BLK][31:16];
  assign host_control = regs[ADDR_HOSTCTL];
  assign clock_control = regs[ADDR_CLKCTL][15:0];
  assign timeout_control = regs[ADDR_CLKCTL][23:16];
  assign srst_all = srst_q[0];
  assign srst_cmd = srst_q[1];
  assign srst_dat = srst_q[2];
endmodule

// File: tb/tb_sd_host_regfile_v2.sv
// tb_sd_host_regfile_v2: randomized and directed checks of the register file against a word-level model
module tb_sd_host_regfile_v2;
  logic clk = 0, reset = 1, req = 0, rw = 0, hw_resp_we = 0, ack, err, cmd_start, srst_all, srst_cmd, srst_dat, irq;
  logic [4:0] addr = 0;
  logic [31:0] data_in = 0, data_out, hw_present_state, cmd_argument, host_control;
  logic [3:0] byte_en = 0;
  logic [127:0] hw_resp_data = 0;
  logic [15:0] hw_nint_set = 0, hw_eint_set = 0, hw_acmd12_err, transfer_mode, command, block_size, block_count, clock_control;
  logic [7:0] timeout_control;
  logic [31:0] m [32];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sd_host_regfile_v2 dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .data_in(data_in), .byte_en(byte_en),
    .data_out(data_out), .ack(ack), .err(err), .hw_resp_we(hw_resp_we), .hw_resp_data(hw_resp_data),
    .hw_present_state(hw_present_state), .hw_nint_set(hw_nint_set), .hw_eint_set(hw_eint_set),
    .hw_acmd12_err(hw_acmd12_err), .cmd_argument(cmd_argument), .transfer_mode(transfer_mode),
    .command(command), .block_size(block_size), .block_count(block_count), .host_control(host_control),
    .clock_control(clock_control), .timeout_control(timeout_control), .cmd_start(cmd_start),
    .srst_all(srst_all), .srst_cmd(srst_cmd), .srst_dat(srst_dat), .irq(irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic r, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be,
                      input logic [15:0] nset, output logic [31:0] q, output logic e, output logic cs);
    int lat = 0;
    @(negedge clk);
    req = 1; rw = r; addr = ad; data_in = d; byte_en = be; hw_nint_set = nset;
    do begin @(negedge clk); lat++; end while (!ack && lat < 8);
    check("ack_latency", 32'(lat), 32'd1);
    q = data_out; e = err; cs = cmd_start;
    req = 0; hw_nint_set = 0;
    @(negedge clk);
    check("ack_width", {31'b0, ack}, 32'd0);
  endtask
  task automatic wr(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] q; logic e, cs;
    xfer(0, ad, d, be, 16'h0, q, e, cs);
  endtask
  task automatic rd_check(input string tag, input logic [4:0] ad, input logic [31:0] exp);
    logic [31:0] q; logic e, cs;
    xfer(1, ad, 32'h0, 4'h0, 16'h0, q, e, cs);
    check(tag, q, exp);
  endtask
  function automatic bit is_bad(int a);
    return a >= 28 || a == 21 || a == 24 || a == 26 || a == 27;
  endfunction
  function automatic bit is_rw(int a);
    return a inside {0, 1, 2, 3, 8, 10, 13, 14, 22, 23};
  endfunction
  function automatic logic [31:0] expect_rd(int a);
    if (is_bad(a)) return 0;
    if (a == 9) return hw_present_state;
    if (a == 15) return {16'h0, hw_acmd12_err};
    if (a == 25) return 32'h0002_0000;
    if (a == 12 || (a >= 16 && a <= 20)) return 0;
    return m[a];
  endfunction
  initial begin
    logic [31:0] q, bm; logic e, cs, r;
    int a, hi, other;
    hw_present_state = $urandom;
    hw_acmd12_err = 16'($urandom);
    for (int i = 0; i < 32; i++) m[i] = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_flags", {25'b0, ack, err, cmd_start, srst_all, srst_cmd, srst_dat, irq}, 0);
    rd_check("rd_w0", 0, 0);
    rd_check("rd_w12", 12, 0);
    rd_check("rd_w25", 25, 32'h0002_0000);
    wr(2, 32'hDEAD_BEEF, 4'b0101);
    m[2] = 32'h00AD_00EF;
    rd_check("rd_w2_be", 2, 32'h00AD_00EF);
    check("cmd_argument", cmd_argument, 32'h00AD_00EF);
    hw_resp_data = {$urandom, $urandom, $urandom, 32'h1234_5678};
    @(negedge clk); hw_resp_we = 1;
    @(negedge clk); hw_resp_we = 0;
    for (int i = 0; i < 4; i++) m[4+i] = hw_resp_data[32*i +: 32];
    rd_check("rd_resp0", 4, 32'h1234_5678);
    rd_check("rd_resp3", 7, m[7]);
    xfer(0, 4, 32'h0, 4'hF, 16'h0, q, e, cs);
    check("ro_write_err", {31'b0, e}, 0);
    rd_check("rd_resp0_kept", 4, 32'h1234_5678);
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 31);
      r = $urandom_range(0, 1) == 1 || a == 11 || a == 12 || a == 20;
      xfer(r, 5'(a), $urandom, 4'($urandom), 16'h0, q, e, cs);
      check("rnd_err", {31'b0, e}, {31'b0, is_bad(a)});
      check("rnd_cmd_start", {31'b0, cs}, {31'b0, !r && a == 3 && byte_en[3]});
      if (r) check("rnd_rd", q, expect_rd(a));
      else if (is_rw(a)) begin
        for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{byte_en[k]}};
        m[a] = (m[a] & ~bm) | (data_in & bm);
      end
    end
    check("out_cmd", {command, transfer_mode}, m[3]);
    check("out_blk", {block_count, block_size}, m[1]);
    check("out_hostctl", host_control, m[10]);
    wr(13, 32'h0001_0001, 4'hF);
    wr(14, 32'h0000_0001, 4'hF);
    @(negedge clk); hw_nint_set = 16'h1;
    @(negedge clk); hw_nint_set = 0;
    check("irq_registered", {31'b0, irq}, 0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 1);
    rd_check("rd_stat_set", 12, 32'h1);
    rd_check("rd_slot_irq", 25, 32'h0002_0001);
    xfer(0, 12, 32'h1, 4'hF, 16'h1, q, e, cs);
    rd_check("set_beats_w1c", 12, 32'h1);
    wr(12, 32'h1, 4'hF);
    rd_check("w1c_clear", 12, 32'h0);
    check("irq_clear", {31'b0, irq}, 0);
    wr(20, 32'h0001_0000, 4'hF);
    rd_check("force_err", 12, 32'h0001_8000);
    wr(12, 32'h0001_0000, 4'hF);
    rd_check("err_w1c", 12, 32'h0);
    wr(11, 32'h0000_3456, 4'hF);
    @(negedge clk);
    req = 1; rw = 0; addr = 11; data_in = 32'h0100_0000; byte_en = 4'b1000;
    hi = 0; other = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) req = 0;
      hi += int'(srst_all);
      other += int'(srst_cmd) + int'(srst_dat);
    end
    check("srst_all_len", 32'(hi), 32'd4);
    check("srst_others", 32'(other), 32'd0);
    rd_check("sra_clr_w2", 2, 32'h0);
    rd_check("sra_keep_w11", 11, 32'h0000_3456);
    rd_check("sra_clr_w13", 13, 32'h0);
    rd_check("bad_addr_rd", 30, 32'h0);
    xfer(1, 30, 32'h0, 4'h0, 16'h0, q, e, cs);
    check("bad_addr_err", {31'b0, e}, 1);
    wr(0, 32'h1111_1111, 4'hF);
    @(negedge clk);
    req = 1; rw = 0; addr = 0; data_in = 32'hFFFF_FFFF; byte_en = 4'hF; reset = 1;
    @(negedge clk);
    check("abort_no_ack", {31'b0, ack}, 0);
    req = 0; reset = 0;
    rd_check("abort_w0", 0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
